// File: rtl/rr_encoder42.sv
// rr_encoder42: captures up to four sticky request lines and issues each pending
// request as a 2-bit code {a,b} through a registered valid/ready slot, round-robin.
module rr_encoder42 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic [CNT_W-1:0] merge_cnt
);
    localparam int SUM_W = CNT_W + 3;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [3:0]       pend_q, pend_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             slot_free;
    logic             have_sel;
    logic             load;
    logic [1:0]       sel;
    logic [3:0]       set_v, clr_v, merge_v;
    logic [2:0]       merge_n;
    logic [SUM_W-1:0] cnt_sum;

    assign slot_free = !valid_q || out_ready;
    assign have_sel  = |pend_q;
    assign load      = have_sel && slot_free;

    // Scan from the farthest offset down so the pending bit closest to ptr wins.
    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        sel = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[ptr_q + 2'(i)]) sel = ptr_q + 2'(i);
        end
    end

    always_comb begin
        set_v   = en ? req : 4'b0000;
        clr_v   = load ? (4'b0001 << sel) : 4'b0000;
        merge_v = set_v & pend_q & ~clr_v;
        merge_n = 3'(merge_v[0]) + 3'(merge_v[1]) + 3'(merge_v[2]) + 3'(merge_v[3]);
        cnt_sum = SUM_W'(cnt_q) + SUM_W'(merge_n);
        cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
        // Set is applied after clear so a same-cycle re-request keeps the bit pending.
        pend_d  = (pend_q & ~clr_v) | set_v;

        ptr_d   = ptr_q;
        valid_d = valid_q;
        code_d  = code_q;
        if (load) begin
            code_d  = sel;
            valid_d = 1'b1;
            ptr_d   = sel + 2'd1;
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= 4'b0000;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign a         = code_q[1];
    assign b         = code_q[0];
    assign busy      = (|pend_q) || valid_q;
    assign merge_cnt = cnt_q;

endmodule

// File: tb/tb_rr_encoder42.sv
// Self-checking bench for rr_encoder42: directed vector table, hand sequences for
// merge saturation, then randomized traffic against a behavioural model.
module tb_rr_encoder42;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       out_ready = 1'b0;

    logic       out_valid, a, b, busy;
    logic [7:0] merge_cnt;
    logic       out_valid2, a2, b2, busy2;
    logic [1:0] merge_cnt2;

    always #5 clk = ~clk;

    rr_encoder42 #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
        .out_valid(out_valid), .a(a), .b(b), .busy(busy), .merge_cnt(merge_cnt)
    );

    rr_encoder42 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
        .out_valid(out_valid2), .a(a2), .b(b2), .busy(busy2), .merge_cnt(merge_cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending set, rotating start index, one output slot,
    // unbounded merge tally clipped to the counter width on comparison.
    logic [3:0] m_pend  = 4'b0000;
    int         m_ptr   = 0;
    logic       m_valid = 1'b0;
    int         m_code  = 0;
    int         m_merges = 0;

    function automatic int clip(input int w);
        int mx;
        mx = (1 << w) - 1;
        return (m_merges > mx) ? mx : m_merges;
    endfunction

    task automatic model_step();
        int         sel;
        bit         free, load;
        logic [3:0] nxt;
        if (!rst_n) begin
            m_pend = 4'b0000; m_ptr = 0; m_valid = 1'b0; m_code = 0; m_merges = 0;
            return;
        end
        free = !m_valid || out_ready;
        sel = -1;
        for (int k = 0; k < 4; k++) begin
            if (sel < 0 && m_pend[(m_ptr + k) % 4]) sel = (m_ptr + k) % 4;
        end
        load = free && (sel >= 0);
        for (int k = 0; k < 4; k++) begin
            if (en && req[k] && m_pend[k] && !(load && sel == k)) m_merges++;
            if (en && req[k])            nxt[k] = 1'b1;
            else if (load && sel == k)   nxt[k] = 1'b0;
            else                         nxt[k] = m_pend[k];
        end
        m_pend = nxt;
        if (load) begin
            m_code  = sel;
            m_valid = 1'b1;
            m_ptr   = (sel + 1) % 4;
        end else if (free) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] q, input logic rdy);
        rst_n = r; en = e; req = q; out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model();
        check("rnd_valid", out_valid, m_valid);
        if (m_valid) check("rnd_code", {a, b}, m_code);
        check("rnd_busy", busy, (|m_pend) || m_valid);
        check("rnd_cnt8", merge_cnt, clip(8));
        check("rnd_cnt2", {out_valid2, busy2, merge_cnt2},
              {m_valid, (|m_pend) || m_valid, 2'(clip(2))});
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] q;
        logic       rdy;
        logic       v;
        logic [1:0] code;
        logic       bz;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [3:0] q, input logic rdy,
                       input logic v, input logic [1:0] code, input logic bz, input int cnt);
        vec_t t;
        t.r = r; t.e = e; t.q = q; t.rdy = rdy; t.v = v; t.code = code; t.bz = bz; t.cnt = cnt;
        tbl.push_back(t);
    endtask

    initial begin
        // reset / idle
        add(0,0,4'b0000,1, 0,0,0,0);
        add(0,0,4'b0000,1, 0,0,0,0);
        add(1,1,4'b0000,1, 0,0,0,0);
        // single request: two-cycle latency, code 2
        add(1,1,4'b0100,1, 0,0,1,0);
        add(1,1,4'b0000,1, 1,2,1,0);
        add(1,1,4'b0000,1, 0,2,0,0);
        // round-robin from reset
        add(0,1,4'b0000,1, 0,0,0,0);
        add(1,1,4'b1111,1, 0,0,1,0);
        add(1,1,4'b0000,1, 1,0,1,0);
        add(1,1,4'b0000,1, 1,1,1,0);
        add(1,1,4'b0000,1, 1,2,1,0);
        add(1,1,4'b0000,1, 1,3,1,0);
        add(1,1,4'b0000,1, 0,3,0,0);
        add(1,1,4'b0011,1, 0,3,1,0);
        add(1,1,4'b0000,1, 1,0,1,0);
        add(1,1,4'b0000,1, 1,1,1,0);
        add(1,1,4'b0000,1, 0,1,0,0);
        // ptr=2: search wraps past 3 to 0
        add(1,1,4'b0011,1, 0,1,1,0);
        add(1,1,4'b0000,1, 1,0,1,0);
        add(1,1,4'b0000,1, 1,1,1,0);
        add(1,1,4'b0000,1, 0,1,0,0);
        // backpressure with ptr=2: code 2 held, then 1
        add(1,1,4'b0110,0, 0,1,1,0);
        add(1,1,4'b0000,0, 1,2,1,0);
        add(1,1,4'b0000,0, 1,2,1,0);
        add(1,1,4'b0000,0, 1,2,1,0);
        add(1,1,4'b0000,0, 1,2,1,0);
        add(1,1,4'b0000,0, 1,2,1,0);
        add(1,1,4'b0000,1, 1,1,1,0);
        add(1,1,4'b0000,1, 0,1,0,0);
        // set-wins on load cycle, then one merge while stalled
        add(1,1,4'b0001,0, 0,1,1,0);
        add(1,1,4'b0001,0, 1,0,1,0);
        add(1,1,4'b0001,0, 1,0,1,1);
        add(1,1,4'b0000,0, 1,0,1,1);
        add(1,1,4'b0000,1, 1,0,1,1);
        add(1,1,4'b0000,1, 0,0,0,1);
        // en gating
        add(1,0,4'b1111,1, 0,0,0,1);
        add(1,0,4'b1111,1, 0,0,0,1);
        // mid-operation reset with pend=1010 and a code in the slot
        add(1,1,4'b1010,0, 0,0,1,1);
        add(1,1,4'b1010,0, 1,1,1,2);
        add(0,1,4'b1010,0, 0,0,0,0);
        add(1,1,4'b0000,1, 0,0,0,0);
        add(1,1,4'b0000,1, 0,0,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].q, tbl[i].rdy);
            check($sformatf("vec%0d_valid", i), out_valid, tbl[i].v);
            check($sformatf("vec%0d_code", i), {a, b}, tbl[i].code);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].bz);
            check($sformatf("vec%0d_cnt8", i), merge_cnt, tbl[i].cnt);
            check($sformatf("vec%0d_cnt2", i), merge_cnt2, (tbl[i].cnt > 3) ? 3 : tbl[i].cnt);
        end

        // five merges while stalled: 8-bit counter reads 5, 2-bit counter saturates at 3
        for (int i = 0; i < 7; i++) step(1, 1, 4'b0001, 0);
        check("sat_cnt8", merge_cnt, 5);
        check("sat_cnt2", merge_cnt2, 3);
        check("sat_slot", {out_valid, a, b}, 3'b100);
        step(1, 1, 4'b0001, 0);
        check("sat_cnt2_hold", merge_cnt2, 3);
        check("sat_cnt8_inc", merge_cnt, 6);
        step(0, 0, 4'b0000, 1);
        check("sat_reset", {out_valid, busy, merge_cnt}, 10'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, e, rdy;
            r   = ($urandom_range(0, 299) != 0);
            e   = ($urandom_range(0, 9) != 0);
            rdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(r, e, 4'($urandom), rdy);
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
